inst_trace_fifo: RTL

- Captures the `{pc, inst}` pair that the single-cycle computer top level presents each CPU clock.
- Tags each pair with a sequence number and buffers it in a first-word-fall-through FIFO.
- A downstream consumer (debug UART framer or display scanner) drains the FIFO over a valid/ready handshake.
- Sits directly downstream of the top-level `pc`/`inst` outputs and runs on the same CPU clock.

---
 rtl/inst_trace_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_trace_fifo.sv
// Instruction trace FIFO: captures {pc, inst} each CPU clock, tags it with a sequence
// number and presents it first-word-fall-through to a valid/ready consumer.
module inst_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter bit SKIP_REPEAT = 1'b0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap_en,
    input  logic          clear,
    input  logic [31:0]   pc,
    input  logic [31:0]   inst,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [15:0]   rd_seq,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [15:0]   drop_cnt
);

    logic [79:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [15:0]   seq_reg, seq_next;
    logic [15:0]   drop_cnt_reg, drop_cnt_next;
    logic          have_last_reg, have_last_next;
    logic [31:0]   last_pc_reg, last_pc_next;
    logic [79:0]   head_reg, head_next;

    logic          repeat_hit, cap, pop, push, drop;
    logic [79:0]   wdata;

    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign rd_valid   = ~empty;
    assign count      = count_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign rd_seq     = head_reg[79:64];
    assign rd_pc      = head_reg[63:32];
    assign rd_inst    = head_reg[31:0];

    assign repeat_hit = have_last_reg & (pc == last_pc_reg);
    assign cap        = cap_en & ~(SKIP_REPEAT & repeat_hit);
    assign pop        = rd_valid & rd_ready;
    assign push       = cap & (~full | pop);
    assign drop       = cap & full & ~pop;
    assign wdata      = {seq_reg, pc, inst};

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        seq_next       = seq_reg;
        drop_cnt_next  = drop_cnt_reg;
        have_last_next = have_last_reg;
        last_pc_next   = last_pc_reg;
        head_next      = head_reg;
        if (clear) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            seq_next       = '0;
            drop_cnt_next  = '0;
            have_last_next = 1'b0;
        end else begin
            if (cap) begin
                have_last_next = 1'b1;
                last_pc_next   = pc;
                seq_next       = seq_reg + 16'd1;
            end
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_next = drop_cnt_reg + 16'd1;
            // Head register tracks the entry visible after this edge; the slot being
            // written this cycle is taken from the write data, not the array.
            if (count_next != '0) begin
                if (push && wr_ptr_reg == rd_ptr_next) head_next = wdata;
                else                                   head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            seq_reg       <= '0;
            drop_cnt_reg  <= '0;
            have_last_reg <= 1'b0;
            last_pc_reg   <= '0;
            head_reg      <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            seq_reg       <= seq_next;
            drop_cnt_reg  <= drop_cnt_next;
            have_last_reg <= have_last_next;
            last_pc_reg   <= last_pc_next;
            head_reg      <= head_next;
        end
    end

    // Storage contents are never reset; the head register masks stale data.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_reg] <= wdata;
    end

endmodule
